data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder side of the CPU MEM-stage load/store interface.
- Services LDUR/STUR doubleword requests from the core's MEM stage through a valid/ready request channel and a valid/ready response channel.
- Latency is configurable, which lets the core's stall logic be exercised.
- Holds a doubleword-organised RAM. Checks alignment and range, and reports errors instead of corrupting memory.

Parameters:
- DEPTH_DW, 128, number of 64-bit doublewords stored; power of two, at least 2.
- LATENCY, 2, cycles from request accept to rsp_valid assertion; at least 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low; sampled on the rising clk edge.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store (STUR), 0 = load (LDUR).
- req_addr  input  64  byte address.
- req_wdata  input  64  store data.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  initiator consumes the response.
- rsp_rdata  output  64  load data; 0 for stores and errored requests.
- rsp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (rst low at a clk edge):
  - State goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - req_ready=1 from the first cycle after reset deasserts.
  - RAM contents are not cleared and are undefined until written.
- States: IDLE, BUSY, RESP.
  - req_ready = (state==IDLE). It is combinational from state only and never depends on req_valid.
- IDLE:
  - Accept occurs when req_valid && req_ready.
  - On accept, capture req_write, req_addr, req_wdata into holding registers, load counter = LATENCY-1, and go to BUSY.
  - Input changes after accept are ignored.
- BUSY:
  - Counter decrements each cycle.
  - When counter==0, the response is formed and the state moves to RESP.
  - rsp_valid rises exactly LATENCY cycles after the accept edge. With LATENCY=1, it is high the cycle immediately after accept.
- Error check, made on the captured address:
  - err = (addr[2:0] != 0) || (addr[63:3] >= DEPTH_DW).
  - Index = addr[3 + log2(DEPTH_DW) - 1 : 3].
- Response formation, on the BUSY to RESP edge:
  - Store without error: the RAM write commits on this edge; rsp_rdata=0, rsp_err=0.
  - Load without error: rsp_rdata = RAM[index], reflecting all previously committed stores; rsp_err=0.
  - Any error: no RAM access, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - On that handshake, the state goes to IDLE and rsp_valid drops the next cycle.
  - req_ready returns the cycle after the handshake, so the minimum request-to-request spacing is LATENCY+2 cycles.
- Backpressure:
  - rsp_ready low holds RESP indefinitely, with no data change.
  - rsp_ready may be high before rsp_valid; it has no effect outside RESP.
- Single outstanding request only; no queueing.
- Reset mid-operation:
  - Reset during BUSY abandons the request, and a pending store never commits.
  - Reset during RESP drops the response; the already-committed store remains in RAM.
- Simultaneous req_valid and reset: reset wins and no accept occurs.

Decomposition:
- Package olivia_mem_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - the constant DW_OFFSET_BITS=3;
  - a function computing the address error flag from address and depth.
- Sub-module dmem_array: DEPTH_DW x 64 RAM with synchronous write enable and combinational read by index.
- The FSM, counter and holding registers live in data_memory_responder.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Store then load, LATENCY=2:
  - Store addr 0x10, data 0xDEADBEEF_CAFEF00D -> rsp_valid exactly 2 cycles after accept, rsp_err=0, rsp_rdata=0.
  - Then load 0x10 -> rsp_rdata=0xDEADBEEF_CAFEF00D.
- Misaligned and out-of-range:
  - Store to 0x13 -> rsp_err=1, and a later load of 0x10 still returns the prior value.
  - Load 0x400 with DEPTH_DW=128 -> rsp_err=1, rsp_rdata=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata stable, req_ready=0 throughout; rsp_ready=1 -> rsp_valid drops next cycle, req_ready rises next cycle.
- Reset mid-BUSY: store 0x1111 to 0x20 over a prior 0x2222, assert rst in BUSY -> no response. After release, load 0x20 returns 0x2222.
- LATENCY=1 with wrap index: store to 0x3F8 (last entry) then load 0x3F8 -> each response one cycle after accept, data matches, rsp_err=0.

Source files
------------

// File: rtl/olivia_mem_pkg.sv
// Shared types and helpers for the MEM-stage data memory responder.
// Holds the FSM state encoding and the doubleword address error check.
package olivia_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    localparam int DW_OFFSET_BITS = 3;

    // Flags a byte address that is not doubleword aligned or lies beyond the array.
    function automatic logic addr_err_f(input logic [63:0] addr, input int unsigned depth_dw);
        logic [63:0] dw_index;
        dw_index = addr >> DW_OFFSET_BITS;
        return (addr[DW_OFFSET_BITS-1:0] != 3'b000) || (dw_index >= 64'(depth_dw));
    endfunction

endpackage

// File: rtl/data_memory_responder_dmem_array.sv
// Doubleword RAM: synchronous write port, combinational read port.
// Contents are never cleared by reset.
module dmem_array #(
    parameter int DEPTH_DW = 128,
    parameter int IDX_W    = $clog2(DEPTH_DW)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [63:0]       wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [63:0]       rdata
);

    logic [63:0] mem_r [DEPTH_DW];

    // Commit a store on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[widx] <= wdata;
        end
    end

    assign rdata = mem_r[ridx];

endmodule

// File: rtl/data_memory_responder.sv
// Responder for LDUR/STUR doubleword requests with configurable latency.
// One request in flight; misaligned or out-of-range requests report rsp_err and never touch the RAM.
module data_memory_responder
    import olivia_mem_pkg::*;
#(
    parameter int DEPTH_DW = 128,
    parameter int LATENCY  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_DW);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    mem_state_e        state_r;
    mem_state_e        state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              hold_write_r;
    logic [63:0]       hold_addr_r;
    logic [63:0]       hold_wdata_r;
    logic              rsp_valid_r;
    logic [63:0]       rsp_rdata_r;
    logic              rsp_err_r;

    logic              accept_s;
    logic              form_s;
    logic              handshake_s;
    logic              err_s;
    logic              ram_we_s;
    logic [IDX_W-1:0]  idx_s;
    logic [63:0]       ram_rdata_s;

    assign req_ready   = (state_r == ST_IDLE);
    assign accept_s    = (state_r == ST_IDLE) && req_valid;
    assign form_s      = (state_r == ST_BUSY) && (cnt_r == {CNT_W{1'b0}});
    assign handshake_s = (state_r == ST_RESP) && rsp_ready;
    assign err_s       = addr_err_f(hold_addr_r, DEPTH_DW);
    assign idx_s       = hold_addr_r[DW_OFFSET_BITS +: IDX_W];
    // Gating with rst keeps a store that is forming on a reset edge from committing.
    assign ram_we_s    = form_s && hold_write_r && !err_s && rst;

    dmem_array #(
        .DEPTH_DW (DEPTH_DW),
        .IDX_W    (IDX_W)
    ) u_dmem_array (
        .clk   (clk),
        .we    (ram_we_s),
        .widx  (idx_s),
        .wdata (hold_wdata_r),
        .ridx  (idx_s),
        .rdata (ram_rdata_s)
    );

    // Next-state selection for the request/response FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register, latency counter, request holding registers and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            hold_write_r <= 1'b0;
            hold_addr_r  <= 64'd0;
            hold_wdata_r <= 64'd0;
            rsp_valid_r  <= 1'b0;
            rsp_rdata_r  <= 64'd0;
            rsp_err_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                hold_write_r <= req_write;
                hold_addr_r  <= req_addr;
                hold_wdata_r <= req_wdata;
                cnt_r        <= CNT_W'(LATENCY - 1);
            end else if ((state_r == ST_BUSY) && (cnt_r != {CNT_W{1'b0}})) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
            if (form_s) begin
                rsp_valid_r <= 1'b1;
                rsp_err_r   <= err_s;
                rsp_rdata_r <= (!hold_write_r && !err_s) ? ram_rdata_s : 64'd0;
            end else if (handshake_s) begin
                rsp_valid_r <= 1'b0;
                rsp_err_r   <= 1'b0;
                rsp_rdata_r <= 64'd0;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a LATENCY=2 instance and a LATENCY=1 instance
// driven from a vector table plus hand-written reset and backpressure sequences.
module tb_data_memory_responder;

    typedef struct {
        int          sel;
        bit          wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        bit          exp_err;
        string       name;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        req_valid_a [2];
    logic        req_ready_a [2];
    logic        req_write_a [2];
    logic [63:0] req_addr_a  [2];
    logic [63:0] req_wdata_a [2];
    logic        rsp_valid_a [2];
    logic        rsp_ready_a [2];
    logic [63:0] rsp_rdata_a [2];
    logic        rsp_err_a   [2];

    int n_chk  = 0;
    int n_fail = 0;
    int exp_lat [2] = '{2, 1};
    vec_t vecs [$];

    data_memory_responder #(.DEPTH_DW(128), .LATENCY(2)) dut_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]), .req_write(req_write_a[0]),
        .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]),
        .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready_a[0]),
        .rsp_rdata(rsp_rdata_a[0]), .rsp_err(rsp_err_a[0])
    );

    data_memory_responder #(.DEPTH_DW(128), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]), .req_write(req_write_a[1]),
        .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]),
        .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready_a[1]),
        .rsp_rdata(rsp_rdata_a[1]), .rsp_err(rsp_err_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request, wait for its response, then complete the handshake.
    task automatic do_txn(input int sel, input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] exp_rdata, input bit exp_err, input bit early, input string name);
        int lat;
        check({name, ".ready_before"}, 64'(req_ready_a[sel]), 64'd1);
        rsp_ready_a[sel] = early;
        req_valid_a[sel] = 1'b1;
        req_write_a[sel] = wr;
        req_addr_a[sel]  = addr;
        req_wdata_a[sel] = wdata;
        tick();
        req_valid_a[sel] = 1'b0;
        req_write_a[sel] = ~wr;
        req_addr_a[sel]  = ~addr;
        req_wdata_a[sel] = ~wdata;
        check({name, ".ready_busy"}, 64'(req_ready_a[sel]), 64'd0);
        lat = 0;
        while (!rsp_valid_a[sel] && lat < 20) begin
            tick();
            lat++;
        end
        check({name, ".latency"}, 64'(lat), 64'(exp_lat[sel]));
        check({name, ".rdata"}, rsp_rdata_a[sel], exp_rdata);
        check({name, ".err"}, 64'(rsp_err_a[sel]), 64'(exp_err));
        rsp_ready_a[sel] = 1'b1;
        tick();
        rsp_ready_a[sel] = 1'b0;
        check({name, ".valid_drop"}, 64'(rsp_valid_a[sel]), 64'd0);
        check({name, ".ready_back"}, 64'(req_ready_a[sel]), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid_a[i] = 1'b0;
            req_write_a[i] = 1'b0;
            req_addr_a[i]  = 64'd0;
            req_wdata_a[i] = 64'd0;
            rsp_ready_a[i] = 1'b0;
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset%0d.req_ready", i), 64'(req_ready_a[i]), 64'd1);
            check($sformatf("reset%0d.rsp_valid", i), 64'(rsp_valid_a[i]), 64'd0);
            check($sformatf("reset%0d.rsp_rdata", i), rsp_rdata_a[i], 64'd0);
            check($sformatf("reset%0d.rsp_err", i), 64'(rsp_err_a[i]), 64'd0);
        end
        tick();
        check("idle.req_ready", 64'(req_ready_a[0]), 64'd1);

        // Request coincident with reset must not be accepted.
        rst = 1'b0;
        req_valid_a[0] = 1'b1;
        req_write_a[0] = 1'b1;
        req_addr_a[0]  = 64'h30;
        req_wdata_a[0] = 64'h5555;
        tick();
        rst = 1'b1;
        req_valid_a[0] = 1'b0;
        check("rst_req.req_ready", 64'(req_ready_a[0]), 64'd1);
        repeat (3) tick();
        check("rst_req.rsp_valid", 64'(rsp_valid_a[0]), 64'd0);

        vecs.push_back(vec_t'{0, 1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 64'd0, 1'b0, "st_10"});
        vecs.push_back(vec_t'{0, 1'b0, 64'h10,  64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0, "ld_10"});
        vecs.push_back(vec_t'{0, 1'b1, 64'h13,  64'h1234, 64'd0, 1'b1, "st_13_misaligned"});
        vecs.push_back(vec_t'{0, 1'b0, 64'h10,  64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0, "ld_10_after_mis"});
        vecs.push_back(vec_t'{0, 1'b0, 64'h400, 64'd0, 64'd0, 1'b1, "ld_400_range"});
        vecs.push_back(vec_t'{0, 1'b1, 64'h410, 64'hBAD0_BAD0, 64'd0, 1'b1, "st_410_alias"});
        vecs.push_back(vec_t'{0, 1'b0, 64'h10,  64'd0, 64'hDEADBEEF_CAFEF00D, 1'b0, "ld_10_after_alias"});
        vecs.push_back(vec_t'{0, 1'b0, 64'h8000_0000_0000_0010, 64'd0, 64'd0, 1'b1, "ld_high_addr"});
        vecs.push_back(vec_t'{0, 1'b1, 64'h18,  64'h01234567_89ABCDEF, 64'd0, 1'b0, "st_18"});
        vecs.push_back(vec_t'{0, 1'b0, 64'h18,  64'd0, 64'h01234567_89ABCDEF, 1'b0, "ld_18"});
        vecs.push_back(vec_t'{0, 1'b0, 64'h3FC, 64'd0, 64'd0, 1'b1, "ld_3fc_misaligned"});
        vecs.push_back(vec_t'{0, 1'b1, 64'h20,  64'h2222, 64'd0, 1'b0, "st_20"});
        vecs.push_back(vec_t'{1, 1'b1, 64'h3F8, 64'hAAAA5555_0F0F1234, 64'd0, 1'b0, "l1_st_3f8"});
        vecs.push_back(vec_t'{1, 1'b0, 64'h3F8, 64'd0, 64'hAAAA5555_0F0F1234, 1'b0, "l1_ld_3f8"});
        vecs.push_back(vec_t'{1, 1'b1, 64'h0,   64'h7777, 64'd0, 1'b0, "l1_st_0"});
        vecs.push_back(vec_t'{1, 1'b0, 64'h0,   64'd0, 64'h7777, 1'b0, "l1_ld_0"});
        vecs.push_back(vec_t'{1, 1'b0, 64'h3FF, 64'd0, 64'd0, 1'b1, "l1_ld_3ff"});

        foreach (vecs[i]) begin
            do_txn(vecs[i].sel, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, 1'b0, vecs[i].name);
        end

        // rsp_ready already high before the response arrives.
        do_txn(0, 1'b0, 64'h18, 64'd0, 64'h01234567_89ABCDEF, 1'b0, 1'b1, "early_ready");

        // Backpressure: response held for 5 cycles.
        req_valid_a[0] = 1'b1;
        req_write_a[0] = 1'b0;
        req_addr_a[0]  = 64'h10;
        tick();
        req_valid_a[0] = 1'b0;
        repeat (2) tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp%0d.rsp_valid", k), 64'(rsp_valid_a[0]), 64'd1);
            check($sformatf("bp%0d.rsp_rdata", k), rsp_rdata_a[0], 64'hDEADBEEF_CAFEF00D);
            check($sformatf("bp%0d.req_ready", k), 64'(req_ready_a[0]), 64'd0);
            tick();
        end
        rsp_ready_a[0] = 1'b1;
        tick();
        rsp_ready_a[0] = 1'b0;
        check("bp.valid_drop", 64'(rsp_valid_a[0]), 64'd0);
        check("bp.ready_back", 64'(req_ready_a[0]), 64'd1);

        // Reset during BUSY abandons a store over 0x2222.
        req_valid_a[0] = 1'b1;
        req_write_a[0] = 1'b1;
        req_addr_a[0]  = 64'h20;
        req_wdata_a[0] = 64'h1111;
        tick();
        req_valid_a[0] = 1'b0;
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        check("rst_busy.rsp_valid", 64'(rsp_valid_a[0]), 64'd0);
        repeat (3) tick();
        check("rst_busy.no_rsp", 64'(rsp_valid_a[0]), 64'd0);
        do_txn(0, 1'b0, 64'h20, 64'd0, 64'h2222, 1'b0, 1'b0, "rst_busy.ld_20");

        // Reset on the very edge a LATENCY=1 store would commit.
        req_valid_a[1] = 1'b1;
        req_write_a[1] = 1'b1;
        req_addr_a[1]  = 64'h3F8;
        req_wdata_a[1] = 64'h1111;
        tick();
        req_valid_a[1] = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst_form.rsp_valid", 64'(rsp_valid_a[1]), 64'd0);
        tick();
        do_txn(1, 1'b0, 64'h3F8, 64'd0, 64'hAAAA5555_0F0F1234, 1'b0, 1'b0, "rst_form.ld_3f8");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
